// File: rtl/idu_regfile.sv
// Integer register file with a per-register busy scoreboard: zero-latency reads with
// writeback bypass, and a stall signal raised while a source still waits on its producer.
module idu_regfile #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic                      use_rs1_i,
    input  logic                      use_rs2_i,
    output logic [DATA_WIDTH-1:0]     rs1_val_o,
    output logic [DATA_WIDTH-1:0]     rs2_val_o,
    input  logic                      wrtbck_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_i,
    input  logic [DATA_WIDTH-1:0]     wrtbck_val_i,
    input  logic                      issue_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd_i,
    output logic                      hazard_o,
    output logic                      wb_unexp_o
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic                  wb_write;
    logic                  rs1_hit;
    logic                  rs2_hit;
    logic                  rs1_pending;
    logic                  rs2_pending;
    logic                  issue_set;

    assign wb_write = wrtbck_en_i && (rd_i != '0);
    assign rs1_hit  = wb_write && (rd_i == rs1_addr_i);
    assign rs2_hit  = wb_write && (rd_i == rs2_addr_i);

    // A writeback landing this cycle resolves the dependency, so it masks the busy bit.
    assign rs1_pending = busy[rs1_addr_i] && !(wrtbck_en_i && (rd_i == rs1_addr_i));
    assign rs2_pending = busy[rs2_addr_i] && !(wrtbck_en_i && (rd_i == rs2_addr_i));

    assign hazard_o   = rst_n && ((use_rs1_i && rs1_pending) || (use_rs2_i && rs2_pending));
    assign wb_unexp_o = rst_n && wb_write && !busy[rd_i];
    assign issue_set  = issue_en_i && (issue_rd_i != '0) && !hazard_o;

    always_comb begin
        rs1_val_o = '0;
        rs2_val_o = '0;
        if (rst_n) begin
            if (rs1_hit)
                rs1_val_o = wrtbck_val_i;
            else if (rs1_addr_i != '0)
                rs1_val_o = regs[rs1_addr_i];
            if (rs2_hit)
                rs2_val_o = wrtbck_val_i;
            else if (rs2_addr_i != '0)
                rs2_val_o = regs[rs2_addr_i];
        end
    end

    // Clear is applied before set so a new producer issued on the same edge keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (wrtbck_en_i)
            busy_nxt[rd_i] = 1'b0;
        if (issue_set)
            busy_nxt[issue_rd_i] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wb_write) begin
            regs[rd_i] <= wrtbck_val_i;
        end
    end

endmodule
